// File: rtl/mem_wb_pkg.sv
// Shared definitions for the MEM/WB stage: bus widths, load-type encoding and
// the alignment rule that decides whether a load is allowed to write back.
package mem_wb_pkg;

    localparam int REG_BUS      = 32;
    localparam int REG_ADDR_BUS = 5;

    localparam logic        ENABLE  = 1'b1;
    localparam logic        DISABLE = 1'b0;
    localparam logic [31:0] ZERO32  = 32'h0000_0000;

    // Load type carried on mem_ldop (LdOpBus = 2:0)
    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LD_LB   = 3'd1,
        LD_LBU  = 3'd2,
        LD_LH   = 3'd3,
        LD_LHU  = 3'd4,
        LD_LW   = 3'd5
    } ld_op_e;

    // Halfwords need an even offset, words need offset zero; bytes always fit.
    function automatic logic is_misaligned(input logic [2:0] ldop, input logic [1:0] off);
        logic bad;
        bad = DISABLE;
        case (ldop)
            LD_LH, LD_LHU: bad = off[0];
            LD_LW:         bad = (off != 2'd0);
            default:       bad = DISABLE;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/hilo_reg.sv
// Architectural HI/LO register pair. Written whenever the write-back stage
// presents a HI/LO write; stall does not gate it because a held entry simply
// rewrites the same values.
module hilo_reg
    import mem_wb_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        we,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    // Store HI/LO on a write request; cleared by asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi_o <= ZERO32;
            lo_o <= ZERO32;
        end else if (we == ENABLE) begin
            hi_o <= hi_i;
            lo_o <= lo_i;
        end
    end

endmodule

// File: rtl/mem_wb.sv
// MEM/WB pipeline register for the 5-stage MIPS core. Formats load data
// (big-endian byte/halfword extraction with sign/zero extension), drives the
// register-file write port one cycle after MEM, and owns the HI/LO pair with
// forwarding of a pending HI/LO write.
module mem_wb
    import mem_wb_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        flush,
    input  logic [4:0]  mem_wd,
    input  logic        mem_wreg,
    input  logic [31:0] mem_wdata,
    input  logic [2:0]  mem_ldop,
    input  logic [1:0]  mem_addr_lo,
    input  logic [31:0] mem_rdata,
    input  logic        mem_whilo,
    input  logic [31:0] mem_hi,
    input  logic [31:0] mem_lo,
    output logic        wb_we,
    output logic [4:0]  wb_waddr,
    output logic [31:0] wb_wdata,
    output logic        wb_whilo,
    output logic [31:0] wb_hi,
    output logic [31:0] wb_lo,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        addr_err
);

    logic [31:0] stored_hi;
    logic [31:0] stored_lo;
    logic [31:0] fmt_data;
    logic        fmt_err;
    logic        fmt_we;

    // Sign-extend a byte by widening it as a signed quantity.
    function automatic logic [31:0] sext8(input logic signed [7:0] v);
        logic signed [31:0] w;
        w = v;
        return w;
    endfunction

    // Sign-extend a halfword by widening it as a signed quantity.
    function automatic logic [31:0] sext16(input logic signed [15:0] v);
        logic signed [31:0] w;
        w = v;
        return w;
    endfunction

    // Build the write-back value for one entry. Offset 0 is the most
    // significant byte (big-endian). Unused load codes behave like NONE.
    function automatic logic [31:0] format_load(
        input logic [2:0]  ldop,
        input logic [1:0]  off,
        input logic [31:0] rdata,
        input logic [31:0] alu
    );
        logic [7:0]  sel_b;
        logic [15:0] sel_h;
        logic [31:0] res;
        case (off)
            2'd0:    sel_b = rdata[31:24];
            2'd1:    sel_b = rdata[23:16];
            2'd2:    sel_b = rdata[15:8];
            default: sel_b = rdata[7:0];
        endcase
        sel_h = off[1] ? rdata[15:0] : rdata[31:16];
        case (ldop)
            LD_LB:   res = sext8(sel_b);
            LD_LBU:  res = {24'h000000, sel_b};
            LD_LH:   res = sext16(sel_h);
            LD_LHU:  res = {16'h0000, sel_h};
            LD_LW:   res = rdata;
            default: res = alu;
        endcase
        return res;
    endfunction

    // Format the incoming entry; a misaligned load neither writes nor carries data,
    // and r0 is never written.
    always_comb begin
        fmt_err  = is_misaligned(mem_ldop, mem_addr_lo);
        fmt_data = fmt_err ? ZERO32 : format_load(mem_ldop, mem_addr_lo, mem_rdata, mem_wdata);
        fmt_we   = mem_wreg && !fmt_err && (mem_wd != 5'd0);
    end

    // Stage register: flush clears, stall holds, otherwise capture the formatted entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_we    <= DISABLE;
            wb_waddr <= 5'd0;
            wb_wdata <= ZERO32;
            wb_whilo <= DISABLE;
            wb_hi    <= ZERO32;
            wb_lo    <= ZERO32;
            addr_err <= DISABLE;
        end else if (flush) begin
            wb_we    <= DISABLE;
            wb_waddr <= 5'd0;
            wb_wdata <= ZERO32;
            wb_whilo <= DISABLE;
            wb_hi    <= ZERO32;
            wb_lo    <= ZERO32;
            addr_err <= DISABLE;
        end else if (!stall) begin
            wb_we    <= fmt_we;
            wb_waddr <= mem_wd;
            wb_wdata <= fmt_data;
            wb_whilo <= mem_whilo;
            wb_hi    <= mem_hi;
            wb_lo    <= mem_lo;
            addr_err <= fmt_err;
        end
    end

    hilo_reg u_hilo (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (wb_whilo),
        .hi_i    (wb_hi),
        .lo_i    (wb_lo),
        .hi_o    (stored_hi),
        .lo_o    (stored_lo)
    );

    // Forward a pending HI/LO write so execute sees it before it is stored.
    always_comb begin
        hi_o = wb_whilo ? wb_hi : stored_hi;
        lo_o = wb_whilo ? wb_lo : stored_lo;
    end

endmodule

// File: tb/tb_mem_wb.sv
// Self-checking bench for mem_wb: directed vector table, stall/flush, HI/LO
// forwarding and asynchronous reset sequences, then randomized traffic
// against a behavioural model of the stage.
module tb_mem_wb;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        flush;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_ldop;
    logic [1:0]  mem_addr_lo;
    logic [31:0] mem_rdata;
    logic        mem_whilo;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        wb_whilo;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        addr_err;

    mem_wb dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_ldop(mem_ldop), .mem_addr_lo(mem_addr_lo), .mem_rdata(mem_rdata),
        .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
        .hi_o(hi_o), .lo_o(lo_o), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model of the architectural state visible at the outputs
    logic        m_we, m_whilo, m_err;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata, m_hi, m_lo, m_shi, m_slo;

    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic [2:0]  ldop;
        logic [1:0]  off;
        logic [31:0] rdata;
        logic        e_we;
        logic [31:0] e_wdata;
        logic        e_err;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Load result computed from the rule text: pick the addressed byte or
    // halfword counting from the top of the word, then extend it.
    task automatic ref_load(input logic [2:0] ldop, input logic [1:0] off,
                            input logic [31:0] rdata, input logic [31:0] alu,
                            output logic [31:0] data, output logic err);
        logic [31:0] v;
        err  = 1'b0;
        data = alu;
        if (ldop == 3'd1 || ldop == 3'd2) begin
            v = (rdata >> (24 - 8 * int'(off))) & 32'hFF;
            if (ldop == 3'd1 && v >= 32'd128) v = v - 32'd256;
            data = v;
        end else if (ldop == 3'd3 || ldop == 3'd4) begin
            if (off % 2 != 0) err = 1'b1;
            else begin
                v = (rdata >> (16 - 8 * int'(off))) & 32'hFFFF;
                if (ldop == 3'd3 && v >= 32'd32768) v = v - 32'd65536;
                data = v;
            end
        end else if (ldop == 3'd5) begin
            if (off != 0) err = 1'b1;
            else data = rdata;
        end
        if (err) data = 32'h0;
    endtask

    task automatic model_clear();
        m_we = 0; m_whilo = 0; m_err = 0; m_waddr = 0;
        m_wdata = 0; m_hi = 0; m_lo = 0; m_shi = 0; m_slo = 0;
    endtask

    // Advance model and DUT by one rising edge, sample 1 time unit later.
    task automatic tick();
        logic [31:0] d;
        logic        e;
        if (m_whilo) begin m_shi = m_hi; m_slo = m_lo; end
        if (flush) begin
            m_we = 0; m_whilo = 0; m_err = 0; m_waddr = 0;
            m_wdata = 0; m_hi = 0; m_lo = 0;
        end else if (!stall) begin
            ref_load(mem_ldop, mem_addr_lo, mem_rdata, mem_wdata, d, e);
            m_we     = mem_wreg && !e && (mem_wd != 0);
            m_waddr  = mem_wd;
            m_wdata  = d;
            m_err    = e;
            m_whilo  = mem_whilo;
            m_hi     = mem_hi;
            m_lo     = mem_lo;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".we"},    32'(wb_we),    32'(m_we));
        chk({tag, ".waddr"}, 32'(wb_waddr), 32'(m_waddr));
        chk({tag, ".wdata"}, wb_wdata,      m_wdata);
        chk({tag, ".err"},   32'(addr_err), 32'(m_err));
        chk({tag, ".whilo"}, 32'(wb_whilo), 32'(m_whilo));
        chk({tag, ".wbhi"},  wb_hi,         m_hi);
        chk({tag, ".wblo"},  wb_lo,         m_lo);
        chk({tag, ".hi_o"},  hi_o,          m_whilo ? m_hi : m_shi);
        chk({tag, ".lo_o"},  lo_o,          m_whilo ? m_lo : m_slo);
    endtask

    task automatic drive(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                         input logic [2:0] ldop, input logic [1:0] off, input logic [31:0] rdata);
        mem_wd = wd; mem_wreg = wreg; mem_wdata = wdata;
        mem_ldop = ldop; mem_addr_lo = off; mem_rdata = rdata;
    endtask

    initial begin
        // wd wreg wdata ldop off rdata | we wdata err
        vecs[0]  = '{5'd3,  1'b1, 32'h0,        3'd1, 2'd1, 32'h12F45678, 1'b1, 32'hFFFFFFF4, 1'b0};
        vecs[1]  = '{5'd3,  1'b1, 32'h0,        3'd2, 2'd1, 32'h12F45678, 1'b1, 32'h000000F4, 1'b0};
        vecs[2]  = '{5'd4,  1'b1, 32'h0,        3'd1, 2'd0, 32'h12F45678, 1'b1, 32'h00000012, 1'b0};
        vecs[3]  = '{5'd4,  1'b1, 32'h0,        3'd1, 2'd3, 32'h12F45678, 1'b1, 32'h00000078, 1'b0};
        vecs[4]  = '{5'd6,  1'b1, 32'h0,        3'd3, 2'd0, 32'h80011234, 1'b1, 32'hFFFF8001, 1'b0};
        vecs[5]  = '{5'd6,  1'b1, 32'h0,        3'd4, 2'd0, 32'h80011234, 1'b1, 32'h00008001, 1'b0};
        vecs[6]  = '{5'd7,  1'b1, 32'h0,        3'd5, 2'd2, 32'h12345678, 1'b0, 32'h00000000, 1'b1};
        vecs[7]  = '{5'd7,  1'b1, 32'h0,        3'd3, 2'd2, 32'h00008001, 1'b1, 32'hFFFF8001, 1'b0};
        vecs[8]  = '{5'd8,  1'b1, 32'h0,        3'd5, 2'd0, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D, 1'b0};
        vecs[9]  = '{5'd8,  1'b1, 32'h0,        3'd3, 2'd1, 32'hCAFEF00D, 1'b0, 32'h00000000, 1'b1};
        vecs[10] = '{5'd9,  1'b1, 32'hDEADBEEF, 3'd0, 2'd3, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
        vecs[11] = '{5'd0,  1'b1, 32'h11112222, 3'd0, 2'd0, 32'h0,        1'b0, 32'h11112222, 1'b0};
        vecs[12] = '{5'd10, 1'b0, 32'h0,        3'd2, 2'd2, 32'h12F45678, 1'b0, 32'h00000056, 1'b0};
        vecs[13] = '{5'd11, 1'b1, 32'h0,        3'd4, 2'd3, 32'h12F45678, 1'b0, 32'h00000000, 1'b1};

        reset_n = 1'b0; stall = 0; flush = 0;
        drive(5'd0, 1'b0, 32'h0, 3'd0, 2'd0, 32'h0);
        mem_whilo = 0; mem_hi = 0; mem_lo = 0;
        model_clear();
        #2;
        check_all("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].wd, vecs[i].wreg, vecs[i].wdata, vecs[i].ldop, vecs[i].off, vecs[i].rdata);
            tick();
            chk($sformatf("vec%0d.we", i),    32'(wb_we),    32'(vecs[i].e_we));
            chk($sformatf("vec%0d.waddr", i), 32'(wb_waddr), 32'(vecs[i].wd));
            chk($sformatf("vec%0d.wdata", i), wb_wdata,      vecs[i].e_wdata);
            chk($sformatf("vec%0d.err", i),   32'(addr_err), 32'(vecs[i].e_err));
            check_all($sformatf("vec%0d.model", i));
        end

        // Stall holds, flush beats stall
        drive(5'd5, 1'b1, 32'hA5A5A5A5, 3'd0, 2'd0, 32'h0);
        tick();
        chk("stall.cap.wdata", wb_wdata, 32'hA5A5A5A5);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            drive(5'(12 + i), 1'b1, 32'h1234 + 32'(i), 3'd0, 2'd0, 32'h0);
            tick();
            chk("stall.hold.waddr", 32'(wb_waddr), 32'd5);
            chk("stall.hold.wdata", wb_wdata, 32'hA5A5A5A5);
            chk("stall.hold.we", 32'(wb_we), 32'd1);
            check_all("stall.model");
        end
        flush = 1;
        tick();
        chk("flush.we", 32'(wb_we), 32'd0);
        chk("flush.wdata", wb_wdata, 32'h0);
        check_all("flush.model");
        stall = 0; flush = 0;

        // HI/LO forwarding then storage
        mem_whilo = 1; mem_hi = 32'h1; mem_lo = 32'h2;
        tick();
        chk("hilo.fwd.hi", hi_o, 32'h1);
        chk("hilo.fwd.lo", lo_o, 32'h2);
        mem_whilo = 0; mem_hi = 32'h7; mem_lo = 32'h8;
        tick();
        chk("hilo.store.hi", hi_o, 32'h1);
        chk("hilo.store.lo", lo_o, 32'h2);
        chk("hilo.store.whilo", 32'(wb_whilo), 32'd0);
        tick();
        check_all("hilo.model");

        // Write to r0, then asynchronous reset mid-stall with a write pending
        drive(5'd0, 1'b1, 32'h55, 3'd0, 2'd0, 32'h0);
        tick();
        chk("r0.we", 32'(wb_we), 32'd0);
        drive(5'd7, 1'b1, 32'h77, 3'd0, 2'd0, 32'h0);
        mem_whilo = 1; mem_hi = 32'h3; mem_lo = 32'h4;
        tick();
        chk("prerst.we", 32'(wb_we), 32'd1);
        stall = 1;
        tick();
        #2;
        reset_n = 1'b0;
        model_clear();
        #1;
        check_all("asyncrst");
        chk("asyncrst.hi_o", hi_o, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        stall = 0;
        mem_whilo = 0;

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom(),
                  3'($urandom_range(0, 5)), 2'($urandom_range(0, 3)), $urandom());
            mem_whilo = 1'($urandom_range(0, 1));
            mem_hi = $urandom(); mem_lo = $urandom();
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 7) == 0);
            tick();
            check_all($sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
